// File: rtl/game_pkg.sv
// Shared game definitions: game-state codes, travel directions, screen
// geometry and the enemy-turn FSM state encoding.
package game_pkg;

   // Game-state codes broadcast by the game-state controller (one-hot).
   localparam logic [3:0] ST_MENU      = 4'b0001;
   localparam logic [3:0] ST_PLAYER    = 4'b0010;
   localparam logic [3:0] ST_GAME_OVER = 4'b0100;
   localparam logic [3:0] ST_ENEMY     = 4'b1000;

   // Active video area; the first blanking pixel after the last active line
   // marks the frame boundary.
   localparam int H_ACTIVE = 1280;
   localparam int V_ACTIVE = 720;

   // Projectile travel direction, encoded as on rotate_in.
   typedef enum logic [1:0] {
      DIR_DOWN  = 2'b00,
      DIR_RIGHT = 2'b01,
      DIR_UP    = 2'b10,
      DIR_LEFT  = 2'b11
   } dir_t;

   // Enemy-turn sequencer states. S_NEXT is the single bookkeeping cycle
   // between a projectile leaving the arena and the next launch.
   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_LAUNCH    = 3'd1,
      S_MOVE      = 3'd2,
      S_NEXT      = 3'd3,
      S_DONE      = 3'd4,
      S_WAIT_EXIT = 3'd5
   } enemy_state_t;

   // An attack is in progress in any state that owns a projectile.
   function automatic logic attack_active(input enemy_state_t s);
      return (s == S_LAUNCH) || (s == S_MOVE) || (s == S_NEXT);
   endfunction

endpackage

// File: rtl/square_sprite.sv
// Square sprite renderer: combinational in-box test against the current
// pixel coordinate, registered colour output (one cycle of latency).
module square_sprite
   import game_pkg::*;
#(
   parameter int SIZE = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enable,
   input  logic signed [11:0] x,
   input  logic signed [11:0] y,
   input  logic        [10:0] hcount,
   input  logic        [9:0]  vcount,
   input  logic        [11:0] color,
   output logic        [11:0] pixel
);

   // 13-bit signed space so a sprite partly left of / above the screen
   // origin still compares correctly against unsigned scan coordinates.
   localparam logic signed [12:0] SIZE_S = 13'(SIZE);

   logic signed [12:0] h_s;
   logic signed [12:0] v_s;
   logic signed [12:0] x_s;
   logic signed [12:0] y_s;
   logic signed [12:0] x_end;
   logic signed [12:0] y_end;
   logic               in_box;

   // Half-open box test: [x, x+SIZE) x [y, y+SIZE).
   always_comb begin
      h_s    = signed'({2'b00, hcount});
      v_s    = signed'({3'b000, vcount});
      x_s    = {x[11], x};
      y_s    = {y[11], y};
      x_end  = x_s + SIZE_S;
      y_end  = y_s + SIZE_S;
      in_box = enable && (h_s >= x_s) && (h_s < x_end) &&
               (v_s >= y_s) && (v_s < y_end);
   end

   // Register the colour so the layer lines up with other registered layers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         pixel <= '0;
      end else begin
         pixel <= in_box ? color : 12'h000;
      end
   end

endmodule

// File: rtl/enemy_turn_ctrl.sv
// Enemy-turn responder: when the game-state controller enters ST_ENEMY it
// fires NUM_BULLETS square projectiles across the arena one after another,
// reports progress, and draws the projectile layer.
//
// Handshake with the game-state controller: state_in==ST_ENEMY is the
// request. The responder holds busy_out high while projectiles are in flight
// and raises finished_out for exactly one cycle when the last one has left
// the arena. Dropping state_in before that cancels the attack silently (no
// finished_out). After finishing, the request must be withdrawn before a new
// attack can be started, so a held request never re-triggers.
module enemy_turn_ctrl
   import game_pkg::*;
#(
   parameter int          BULLET_SIZE  = 16,
   parameter int          BULLET_SPEED = 4,
   parameter int          NUM_BULLETS  = 4,
   parameter int          ARENA_X0     = 512,
   parameter int          ARENA_Y0     = 232,
   parameter int          ARENA_SIZE   = 256,
   parameter int          LANE_STEP    = 64,
   parameter logic [11:0] BULLET_COLOR = 12'hF00
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [10:0] hcount_in,
   input  logic [9:0]  vcount_in,
   input  logic [3:0]  state_in,
   input  logic [3:0]  turn_in,
   input  logic [1:0]  rotate_in,
   output logic        busy_out,
   output logic        finished_out,
   output logic [11:0] pixel_out
);

   // Arena geometry in the 12-bit signed coordinate space of the projectile.
   localparam logic signed [11:0] X0_S    = 12'(ARENA_X0);
   localparam logic signed [11:0] Y0_S    = 12'(ARENA_Y0);
   localparam logic signed [11:0] FAR_X_S = 12'(ARENA_X0 + ARENA_SIZE - BULLET_SIZE);
   localparam logic signed [11:0] FAR_Y_S = 12'(ARENA_Y0 + ARENA_SIZE - BULLET_SIZE);
   localparam logic signed [11:0] END_X_S = 12'(ARENA_X0 + ARENA_SIZE);
   localparam logic signed [11:0] END_Y_S = 12'(ARENA_Y0 + ARENA_SIZE);
   localparam logic signed [11:0] SPEED_S = 12'(BULLET_SPEED);
   localparam logic signed [11:0] SIZE_S  = 12'(BULLET_SIZE);
   localparam logic        [4:0]  NUM_B   = 5'(NUM_BULLETS);

   enemy_state_t       state;
   enemy_state_t       state_next;

   dir_t               dir;
   logic [1:0]         seed;
   logic [3:0]         count;
   logic signed [11:0] pos_x;
   logic signed [11:0] pos_y;

   logic               enemy_cmd;
   logic               frame_tick;
   logic [1:0]         lane;
   logic signed [11:0] lane_off;
   logic signed [11:0] launch_x;
   logic signed [11:0] launch_y;
   logic signed [11:0] step_x;
   logic signed [11:0] step_y;
   logic               exit_hit;
   logic [4:0]         count_inc;
   logic               more_left;
   logic               sprite_en;

   // Upper turn bits do not affect the lane pattern.
   logic               unused_turn_bits;
   assign unused_turn_bits = &{1'b0, turn_in[3:2]};

   assign enemy_cmd  = (state_in == ST_ENEMY);
   // First blanking pixel after the active area: one pulse per frame while
   // the scan counters advance.
   assign frame_tick = (hcount_in == 11'(H_ACTIVE)) && (vcount_in == 10'(V_ACTIVE));

   // Launch position: lane chosen by bullet index rotated by the turn seed,
   // spaced along the axis perpendicular to travel; start edge set by dir.
   always_comb begin
      lane     = count[1:0] + seed;
      lane_off = 12'(LANE_STEP * int'(lane));
      launch_x = X0_S + lane_off;
      launch_y = Y0_S + lane_off;
      case (dir)
         DIR_DOWN:  launch_y = Y0_S;
         DIR_UP:    launch_y = FAR_Y_S;
         DIR_RIGHT: launch_x = X0_S;
         DIR_LEFT:  launch_x = FAR_X_S;
         default:   launch_y = Y0_S;
      endcase
   end

   // One frame of travel and the exit test on the moved position; signed
   // arithmetic lets up/left go below the arena edge without wrapping.
   always_comb begin
      step_x   = pos_x;
      step_y   = pos_y;
      exit_hit = 1'b0;
      case (dir)
         DIR_DOWN: begin
            step_y   = pos_y + SPEED_S;
            exit_hit = (step_y >= END_Y_S);
         end
         DIR_RIGHT: begin
            step_x   = pos_x + SPEED_S;
            exit_hit = (step_x >= END_X_S);
         end
         DIR_UP: begin
            step_y   = pos_y - SPEED_S;
            exit_hit = ((step_y + SIZE_S) <= Y0_S);
         end
         DIR_LEFT: begin
            step_x   = pos_x - SPEED_S;
            exit_hit = ((step_x + SIZE_S) <= X0_S);
         end
         default: begin
            step_x   = pos_x;
            step_y   = pos_y;
            exit_hit = 1'b0;
         end
      endcase
   end

   // Bullet bookkeeping: the count after this bullet and whether more remain.
   always_comb begin
      count_inc = {1'b0, count} + 5'd1;
      more_left = (count_inc < NUM_B);
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // FSM next-state logic; a withdrawn request aborts ahead of any exit.
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: begin
            if (enemy_cmd) state_next = S_LAUNCH;
         end
         S_LAUNCH: begin
            state_next = enemy_cmd ? S_MOVE : S_IDLE;
         end
         S_MOVE: begin
            if (!enemy_cmd)                  state_next = S_IDLE;
            else if (frame_tick && exit_hit) state_next = S_NEXT;
         end
         S_NEXT: begin
            if (!enemy_cmd)     state_next = S_IDLE;
            else if (more_left) state_next = S_LAUNCH;
            else                state_next = S_DONE;
         end
         S_DONE: begin
            state_next = S_WAIT_EXIT;
         end
         S_WAIT_EXIT: begin
            if (!enemy_cmd) state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // FSM outputs; the sprite is blanked as soon as the request is withdrawn.
   always_comb begin
      busy_out     = attack_active(state);
      finished_out = (state == S_DONE);
      sprite_en    = attack_active(state) && enemy_cmd;
   end

   // Attack datapath: latch parameters at start, place and move the bullet,
   // advance the bullet count after each exit.
   always_ff @(posedge clk) begin
      if (!rst) begin
         dir   <= DIR_DOWN;
         seed  <= 2'd0;
         count <= 4'd0;
         pos_x <= 12'sd0;
         pos_y <= 12'sd0;
      end else begin
         if ((state == S_IDLE) && enemy_cmd) begin
            dir   <= dir_t'(rotate_in);
            seed  <= turn_in[1:0];
            count <= 4'd0;
         end
         if (state == S_LAUNCH) begin
            pos_x <= launch_x;
            pos_y <= launch_y;
         end
         if ((state == S_MOVE) && enemy_cmd && frame_tick) begin
            pos_x <= step_x;
            pos_y <= step_y;
         end
         if ((state == S_NEXT) && enemy_cmd) begin
            count <= count_inc[3:0];
         end
      end
   end

   square_sprite #(
      .SIZE (BULLET_SIZE)
   ) u_sprite (
      .clk    (clk),
      .rst    (rst),
      .enable (sprite_en),
      .x      (pos_x),
      .y      (pos_y),
      .hcount (hcount_in),
      .vcount (vcount_in),
      .color  (BULLET_COLOR),
      .pixel  (pixel_out)
   );

endmodule

// File: tb/tb_enemy_turn_ctrl.sv
// Bench for enemy_turn_ctrl: reset, full attacks, lane placement, up exit
// timing, abort and re-arm, with a pixel scoreboard and a lane vector table.
module tb_enemy_turn_ctrl;
   import game_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [10:0] hcount;
   logic [9:0]  vcount;
   logic [3:0]  state_in;
   logic [3:0]  turn_in;
   logic [1:0]  rotate_in;
   logic        busy_out;
   logic        finished_out;
   logic [11:0] pixel_out;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          fin_seen = 0;
   logic [11:0] exp_q[$];

   typedef struct {
      logic [10:0] hc;
      logic [9:0]  vc;
      logic [11:0] pix;
   } vec_t;
   vec_t lane_tab[8];

   enemy_turn_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .hcount_in    (hcount),
      .vcount_in    (vcount),
      .state_in     (state_in),
      .turn_in      (turn_in),
      .rotate_in    (rotate_in),
      .busy_out     (busy_out),
      .finished_out (finished_out),
      .pixel_out    (pixel_out)
   );

   // Clock.
   always #5 clk = ~clk;

   // Watchdog.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
      if (finished_out) fin_seen++;
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // Address a pixel, queue its expected colour, compare one cycle later.
   task automatic probe(input string name, input logic [10:0] hc, input logic [9:0] vc,
                        input logic [11:0] exp);
      logic [11:0] e;
      hcount = hc;
      vcount = vc;
      exp_q.push_back(exp);
      step();
      e = exp_q.pop_front();
      check(name, int'(pixel_out), int'(e));
   endtask

   // One frame tick followed by three quiet cycles, enough for the
   // between-bullet bookkeeping to finish before the next tick.
   task automatic frame_tick_seq();
      hcount = 11'd1280;
      vcount = 10'd720;
      step();
      hcount = 11'd0;
      vcount = 10'd0;
      repeat (3) step();
   endtask

   task automatic run_attack(input int max_ticks, output int ticks);
      ticks = 0;
      while (busy_out && ticks < max_ticks) begin
         frame_tick_seq();
         ticks++;
      end
   endtask

   function automatic logic [11:0] model_pix(input int hc, input int vc, input int bx, input int by);
      return (hc >= bx && hc < bx + 16 && vc >= by && vc < by + 16) ? 12'hF00 : 12'h000;
   endfunction

   initial begin
      int ticks;
      int fb;
      int seen;
      int busy_cnt;
      int rh;
      int rv;

      // Right-travel bullet 0 with seed 1 sits at (512,296).
      lane_tab[0] = '{11'd520, 10'd300, 12'hF00};
      lane_tab[1] = '{11'd540, 10'd300, 12'h000};
      lane_tab[2] = '{11'd512, 10'd296, 12'hF00};
      lane_tab[3] = '{11'd527, 10'd311, 12'hF00};
      lane_tab[4] = '{11'd528, 10'd300, 12'h000};
      lane_tab[5] = '{11'd511, 10'd300, 12'h000};
      lane_tab[6] = '{11'd520, 10'd295, 12'h000};
      lane_tab[7] = '{11'd520, 10'd312, 12'h000};

      rst = 1'b0;
      state_in = ST_ENEMY;
      turn_in = 4'd0;
      rotate_in = 2'b00;
      hcount = 11'd0;
      vcount = 10'd0;

      // Reset held with the request asserted.
      repeat (3) begin
         step();
         check("reset_busy", int'(busy_out), 0);
         check("reset_finished", int'(finished_out), 0);
         check("reset_pixel", int'(pixel_out), 0);
      end
      rst = 1'b1;
      seen = 0;
      for (int i = 0; i < 2; i++) begin
         step();
         if (busy_out) begin
            seen = 1;
            break;
         end
      end
      check("busy_after_reset", seen, 1);
      step();

      // Full down attack.
      probe("down_first_pixel", 11'd512, 10'd232, 12'hF00);
      fb = fin_seen;
      run_attack(300, ticks);
      check("down_ticks", ticks, 256);
      check("down_finished_cycles", fin_seen - fb, 1);
      check("down_busy_end", int'(busy_out), 0);
      busy_cnt = 0;
      repeat (20) begin
         step();
         if (busy_out) busy_cnt++;
      end
      check("no_restart_busy", busy_cnt, 0);
      check("no_restart_finished", fin_seen - fb, 1);

      // Lane placement: right travel, seed 1.
      state_in = 4'b0000;
      step();
      turn_in = 4'd1;
      rotate_in = 2'b01;
      state_in = ST_ENEMY;
      step();
      step();
      for (int i = 0; i < 8; i++) begin
         probe($sformatf("lane_tab_%0d", i), lane_tab[i].hc, lane_tab[i].vc, lane_tab[i].pix);
      end
      for (int i = 0; i < 10; i++) begin
         rh = $urandom_range(535, 500);
         rv = $urandom_range(320, 285);
         probe($sformatf("lane_rand_%0d", i), 11'(rh), 10'(rv), model_pix(rh, rv, 512, 296));
      end
      repeat (64) frame_tick_seq();
      check("lane_second_busy", int'(busy_out), 1);
      probe("lane_second_pos", 11'd512, 10'd360, 12'hF00);
      probe("lane_first_gone", 11'd512, 10'd296, 12'h000);
      repeat (5) frame_tick_seq();
      probe("lane_moved_in", 11'd532, 10'd360, 12'hF00);
      probe("lane_moved_left_edge", 11'd531, 10'd360, 12'h000);
      probe("lane_moved_right_in", 11'd547, 10'd360, 12'hF00);
      probe("lane_moved_right_out", 11'd548, 10'd360, 12'h000);

      // Abort mid-move.
      fb = fin_seen;
      state_in = 4'b0000;
      probe("abort_pixel", 11'd532, 10'd360, 12'h000);
      check("abort_busy", int'(busy_out), 0);
      check("abort_finished", int'(finished_out), 0);
      repeat (4) step();
      check("abort_no_finish", fin_seen - fb, 0);
      check("abort_idle_busy", int'(busy_out), 0);
      state_in = ST_ENEMY;
      step();
      step();
      probe("reenter_count0", 11'd512, 10'd296, 12'hF00);
      probe("reenter_not_lane2", 11'd512, 10'd360, 12'h000);

      // Up exit timing.
      state_in = 4'b0000;
      step();
      turn_in = 4'd0;
      rotate_in = 2'b10;
      state_in = ST_ENEMY;
      step();
      step();
      probe("up_start", 11'd512, 10'd472, 12'hF00);
      probe("up_start_above", 11'd512, 10'd471, 12'h000);
      repeat (63) frame_tick_seq();
      probe("up_tick63_pos", 11'd512, 10'd220, 12'hF00);
      check("up_tick63_busy", int'(busy_out), 1);
      frame_tick_seq();
      probe("up_next_bullet", 11'd576, 10'd472, 12'hF00);
      probe("up_old_gone", 11'd512, 10'd216, 12'h000);
      fb = fin_seen;
      run_attack(300, ticks);
      check("up_remaining_ticks", ticks, 192);
      check("up_finished_cycles", fin_seen - fb, 1);

      // Re-arm after completion.
      state_in = 4'b0000;
      step();
      rotate_in = 2'b00;
      state_in = ST_ENEMY;
      step();
      check("rearm_busy", int'(busy_out), 1);
      step();
      fb = fin_seen;
      run_attack(300, ticks);
      check("rearm_ticks", ticks, 256);
      check("rearm_finished_cycles", fin_seen - fb, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
